// File: rtl/ex_mem_stage.sv
// EX/MEM stage: registers ALU results, resolves branches/JAL into PC redirects,
// and runs LW/SW through a req/ack data-memory port, stalling execute meanwhile.
module ex_mem_stage #(
  parameter int          DBITS      = 32,
  parameter int          REGNOBITS  = 4,
  parameter int          OPCODEBITS = 5,
  parameter logic [31:0] INSTSIZE   = 32'd4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [OPCODEBITS-1:0] OPCODE,
  input  logic                  ALUR,
  input  logic [DBITS-1:0]      ALUOUT,
  input  logic                  Z,
  input  logic [DBITS-1:0]      PCPLUS4,
  input  logic [DBITS-1:0]      BRTARGET,
  input  logic [DBITS-1:0]      STDATA,
  input  logic [REGNOBITS-1:0]  DSTREG,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [DBITS-1:0]      MEM_ADDR,
  output logic [DBITS-1:0]      MEM_WDATA,
  input  logic                  MEM_ACK,
  input  logic [DBITS-1:0]      MEM_RDATA,
  output logic                  WB_EN,
  output logic [REGNOBITS-1:0]  WB_REG,
  output logic [DBITS-1:0]      WB_DATA,
  output logic                  PC_REDIRECT,
  output logic [DBITS-1:0]      PC_TARGET,
  output logic                  ILLEGAL
);

  localparam logic [OPCODEBITS-1:0] OP_ADDI = OPCODEBITS'(5'b11000);
  localparam logic [OPCODEBITS-1:0] OP_ANDI = OPCODEBITS'(5'b11100);
  localparam logic [OPCODEBITS-1:0] OP_ORI  = OPCODEBITS'(5'b11101);
  localparam logic [OPCODEBITS-1:0] OP_XORI = OPCODEBITS'(5'b11110);
  localparam logic [OPCODEBITS-1:0] OP_BEQ  = OPCODEBITS'(5'b10000);
  localparam logic [OPCODEBITS-1:0] OP_BLT  = OPCODEBITS'(5'b10001);
  localparam logic [OPCODEBITS-1:0] OP_BLE  = OPCODEBITS'(5'b10010);
  localparam logic [OPCODEBITS-1:0] OP_BNE  = OPCODEBITS'(5'b10011);
  localparam logic [OPCODEBITS-1:0] OP_JAL  = OPCODEBITS'(5'b10111);
  localparam logic [OPCODEBITS-1:0] OP_LW   = OPCODEBITS'(5'b01010);
  localparam logic [OPCODEBITS-1:0] OP_SW   = OPCODEBITS'(5'b01110);

  // JAL targets are forced onto an instruction boundary
  localparam logic [DBITS-1:0] JAL_MASK = ~(DBITS'(INSTSIZE) - DBITS'(1));

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t               state;
  logic [REGNOBITS-1:0] load_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      load_reg    <= '0;
      IN_READY    <= 1'b0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      WB_EN       <= 1'b0;
      WB_REG      <= '0;
      WB_DATA     <= '0;
      PC_REDIRECT <= 1'b0;
      PC_TARGET   <= '0;
      ILLEGAL     <= 1'b0;
    end else begin
      WB_EN       <= 1'b0;
      PC_REDIRECT <= 1'b0;
      case (state)
        IDLE: begin
          IN_READY <= 1'b1;
          if (IN_VALID && IN_READY) begin
            if (ALUR) begin
              WB_EN   <= 1'b1;
              WB_REG  <= DSTREG;
              WB_DATA <= ALUOUT;
            end else begin
              case (OPCODE)
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                  WB_EN   <= 1'b1;
                  WB_REG  <= DSTREG;
                  WB_DATA <= ALUOUT;
                end
                OP_BEQ, OP_BLT, OP_BLE, OP_BNE: begin
                  if (Z) begin
                    PC_REDIRECT <= 1'b1;
                    PC_TARGET   <= BRTARGET;
                  end
                end
                OP_JAL: begin
                  WB_EN       <= 1'b1;
                  WB_REG      <= DSTREG;
                  WB_DATA     <= PCPLUS4;
                  PC_REDIRECT <= 1'b1;
                  PC_TARGET   <= ALUOUT & JAL_MASK;
                end
                OP_LW, OP_SW: begin
                  // Misaligned word accesses never reach memory
                  if (ALUOUT[1:0] != 2'b00) begin
                    ILLEGAL <= 1'b1;
                  end else begin
                    MEM_REQ  <= 1'b1;
                    MEM_WE   <= (OPCODE == OP_SW);
                    MEM_ADDR <= ALUOUT;
                    if (OPCODE == OP_SW) MEM_WDATA <= STDATA;
                    load_reg <= DSTREG;
                    IN_READY <= 1'b0;
                    state    <= MEM_WAIT;
                  end
                end
                default: ILLEGAL <= 1'b1;
              endcase
            end
          end
        end
        MEM_WAIT: begin
          if (MEM_ACK) begin
            MEM_REQ  <= 1'b0;
            IN_READY <= 1'b1;
            state    <= IDLE;
            if (!MEM_WE) begin
              WB_EN   <= 1'b1;
              WB_REG  <= load_reg;
              WB_DATA <= MEM_RDATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: inputs change and outputs are sampled 1ns
// after each rising edge, so a check there sees the registered cycle-k+1 values.
module tb_ex_mem_stage;

  localparam logic [4:0] OP_ADDI = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10111;
  localparam logic [4:0] OP_LW   = 5'b01010;
  localparam logic [4:0] OP_SW   = 5'b01110;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [4:0]  OPCODE;
  logic        ALUR;
  logic [31:0] ALUOUT;
  logic        Z;
  logic [31:0] PCPLUS4;
  logic [31:0] BRTARGET;
  logic [31:0] STDATA;
  logic [3:0]  DSTREG;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        WB_EN;
  logic [3:0]  WB_REG;
  logic [31:0] WB_DATA;
  logic        PC_REDIRECT;
  logic [31:0] PC_TARGET;
  logic        ILLEGAL;

  int vectors = 0;
  int miscompares = 0;

  ex_mem_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .ALUR(ALUR), .ALUOUT(ALUOUT), .Z(Z), .PCPLUS4(PCPLUS4),
    .BRTARGET(BRTARGET), .STDATA(STDATA), .DSTREG(DSTREG), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .WB_EN(WB_EN), .WB_REG(WB_REG), .WB_DATA(WB_DATA),
    .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic alur, input logic [4:0] op,
                                input logic [31:0] aluout, input logic [3:0] dst);
    IN_VALID = valid;
    ALUR     = alur;
    OPCODE   = op;
    ALUOUT   = aluout;
    DSTREG   = dst;
  endtask

  initial begin
    RESET_N = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = '0; Z = 1'b0;
    PCPLUS4 = '0; BRTARGET = '0; STDATA = '0;
    apply_stimulus(1'b0, 1'b0, 5'b0, 32'h0, 4'h0);
    #2;
    check_output("reset_in_ready", 32'(IN_READY), 32'h0);
    check_output("reset_mem_req", 32'(MEM_REQ), 32'h0);
    check_output("reset_wb_en", 32'(WB_EN), 32'h0);
    check_output("reset_illegal", 32'(ILLEGAL), 32'h0);
    #8 RESET_N = 1'b1;
    next_cycle();
    check_output("ready_after_release", 32'(IN_READY), 32'h1);

    // Reset in the middle of an outstanding load abandons it
    apply_stimulus(1'b1, 1'b0, OP_LW, 32'h100, 4'd3);
    next_cycle();
    check_output("rst_lw_req", 32'(MEM_REQ), 32'h1);
    check_output("rst_lw_addr", MEM_ADDR, 32'h100);
    check_output("rst_lw_ready", 32'(IN_READY), 32'h0);
    IN_VALID = 1'b0;
    next_cycle();
    check_output("rst_lw_req_held", 32'(MEM_REQ), 32'h1);
    RESET_N = 1'b0;
    #1;
    check_output("rst_async_req", 32'(MEM_REQ), 32'h0);
    check_output("rst_async_ready", 32'(IN_READY), 32'h0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'hBAD0BAD0;
    next_cycle();
    check_output("rst_hold_wb", 32'(WB_EN), 32'h0);
    #3 RESET_N = 1'b1; MEM_ACK = 1'b0;
    next_cycle();
    check_output("rst_rel_ready", 32'(IN_READY), 32'h1);
    check_output("rst_rel_illegal", 32'(ILLEGAL), 32'h0);
    check_output("rst_rel_wb", 32'(WB_EN), 32'h0);
    check_output("rst_rel_req", 32'(MEM_REQ), 32'h0);

    // Back-to-back ALU writebacks; OPCODE is ignored when ALUR=1
    apply_stimulus(1'b1, 1'b1, 5'b00000, 32'hDEADBEEF, 4'd5);
    next_cycle();
    check_output("alur_wb_en", 32'(WB_EN), 32'h1);
    check_output("alur_wb_reg", 32'(WB_REG), 32'h5);
    check_output("alur_wb_data", WB_DATA, 32'hDEADBEEF);
    check_output("alur_ready", 32'(IN_READY), 32'h1);
    apply_stimulus(1'b1, 1'b0, OP_ADDI, 32'h7, 4'd6);
    next_cycle();
    check_output("addi_wb_en", 32'(WB_EN), 32'h1);
    check_output("addi_wb_reg", 32'(WB_REG), 32'h6);
    check_output("addi_wb_data", WB_DATA, 32'h7);
    check_output("addi_illegal", 32'(ILLEGAL), 32'h0);
    IN_VALID = 1'b0;
    next_cycle();
    check_output("wb_pulse_ends", 32'(WB_EN), 32'h0);

    // Taken BEQ then untaken BNE
    apply_stimulus(1'b1, 1'b0, OP_BEQ, 32'h1, 4'd1);
    Z = 1'b1; BRTARGET = 32'h40;
    next_cycle();
    check_output("beq_redirect", 32'(PC_REDIRECT), 32'h1);
    check_output("beq_target", PC_TARGET, 32'h40);
    check_output("beq_wb_en", 32'(WB_EN), 32'h0);
    apply_stimulus(1'b1, 1'b0, OP_BNE, 32'h0, 4'd1);
    Z = 1'b0; BRTARGET = 32'h80;
    next_cycle();
    check_output("bne_no_redirect", 32'(PC_REDIRECT), 32'h0);
    check_output("bne_target_held", PC_TARGET, 32'h40);
    check_output("bne_wb_en", 32'(WB_EN), 32'h0);

    // JAL: link writeback and aligned redirect in the same cycle
    apply_stimulus(1'b1, 1'b0, OP_JAL, 32'h203, 4'd15);
    Z = 1'b1; PCPLUS4 = 32'h14;
    next_cycle();
    check_output("jal_wb_en", 32'(WB_EN), 32'h1);
    check_output("jal_wb_reg", 32'(WB_REG), 32'hF);
    check_output("jal_wb_data", WB_DATA, 32'h14);
    check_output("jal_redirect", 32'(PC_REDIRECT), 32'h1);
    check_output("jal_target", PC_TARGET, 32'h200);
    IN_VALID = 1'b0;
    next_cycle();
    check_output("jal_redirect_ends", 32'(PC_REDIRECT), 32'h0);

    // LW with three wait cycles; a pending ALU op waits behind it
    apply_stimulus(1'b1, 1'b0, OP_LW, 32'h80, 4'd9);
    next_cycle();
    check_output("lw_req_c1", 32'(MEM_REQ), 32'h1);
    check_output("lw_we_c1", 32'(MEM_WE), 32'h0);
    check_output("lw_addr_c1", MEM_ADDR, 32'h80);
    check_output("lw_ready_c1", 32'(IN_READY), 32'h0);
    apply_stimulus(1'b1, 1'b1, 5'b0, 32'h55, 4'd2);
    next_cycle();
    check_output("lw_req_c2", 32'(MEM_REQ), 32'h1);
    check_output("lw_addr_c2", MEM_ADDR, 32'h80);
    check_output("lw_wb_c2", 32'(WB_EN), 32'h0);
    next_cycle();
    check_output("lw_req_c3", 32'(MEM_REQ), 32'h1);
    check_output("lw_addr_c3", MEM_ADDR, 32'h80);
    check_output("lw_ready_c3", 32'(IN_READY), 32'h0);
    check_output("lw_wb_c3", 32'(WB_EN), 32'h0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234;
    next_cycle();
    MEM_ACK = 1'b0;
    check_output("lw_req_drop", 32'(MEM_REQ), 32'h0);
    check_output("lw_wb_en", 32'(WB_EN), 32'h1);
    check_output("lw_wb_reg", 32'(WB_REG), 32'h9);
    check_output("lw_wb_data", WB_DATA, 32'h1234);
    check_output("lw_ready_back", 32'(IN_READY), 32'h1);
    next_cycle();
    IN_VALID = 1'b0;
    check_output("after_lw_wb_en", 32'(WB_EN), 32'h1);
    check_output("after_lw_wb_reg", 32'(WB_REG), 32'h2);
    check_output("after_lw_wb_data", WB_DATA, 32'h55);

    // LW acknowledged in its first cycle writes back at k+2
    apply_stimulus(1'b1, 1'b0, OP_LW, 32'h90, 4'd4);
    next_cycle();
    check_output("lw1_req", 32'(MEM_REQ), 32'h1);
    check_output("lw1_wb_k1", 32'(WB_EN), 32'h0);
    IN_VALID = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFE;
    next_cycle();
    MEM_ACK = 1'b0;
    check_output("lw1_req_drop", 32'(MEM_REQ), 32'h0);
    check_output("lw1_wb_en", 32'(WB_EN), 32'h1);
    check_output("lw1_wb_reg", 32'(WB_REG), 32'h4);
    check_output("lw1_wb_data", WB_DATA, 32'hCAFE);

    // Stray acknowledge while idle is ignored
    MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF0000;
    next_cycle();
    MEM_ACK = 1'b0;
    check_output("idle_ack_wb", 32'(WB_EN), 32'h0);
    check_output("idle_ack_data", WB_DATA, 32'hCAFE);

    // Misaligned SW is illegal and the flag is sticky
    apply_stimulus(1'b1, 1'b0, OP_SW, 32'h82, 4'd0);
    STDATA = 32'h11;
    next_cycle();
    IN_VALID = 1'b0;
    check_output("sw_mis_req", 32'(MEM_REQ), 32'h0);
    check_output("sw_mis_illegal", 32'(ILLEGAL), 32'h1);
    check_output("sw_mis_ready", 32'(IN_READY), 32'h1);
    next_cycle();
    check_output("illegal_sticky", 32'(ILLEGAL), 32'h1);

    // Aligned SW: write request, no writeback
    apply_stimulus(1'b1, 1'b0, OP_SW, 32'h84, 4'd7);
    STDATA = 32'hA5;
    next_cycle();
    IN_VALID = 1'b0;
    check_output("sw_req", 32'(MEM_REQ), 32'h1);
    check_output("sw_we", 32'(MEM_WE), 32'h1);
    check_output("sw_addr", MEM_ADDR, 32'h84);
    check_output("sw_wdata", MEM_WDATA, 32'hA5);
    check_output("sw_wb_k1", 32'(WB_EN), 32'h0);
    MEM_ACK = 1'b1;
    next_cycle();
    MEM_ACK = 1'b0;
    check_output("sw_req_drop", 32'(MEM_REQ), 32'h0);
    check_output("sw_no_wb", 32'(WB_EN), 32'h0);
    check_output("sw_ready_back", 32'(IN_READY), 32'h1);
    check_output("sw_illegal_kept", 32'(ILLEGAL), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Stage directly downstream of the ALU. Registers the ALU result (ALUOUT) and the branch condition (Z) for one instruction at a time.
- Resolves branches and JAL into a PC redirect.
- Performs LW/SW through a request/acknowledge data-memory port.
- Presents a single-cycle register-writeback pulse to the register file.
- Holds one instruction at a time and back-pressures the execute stage while a memory access is outstanding.

Parameters:
- DBITS, 32, data/address width
- REGNOBITS, 4, register-number width
- OPCODEBITS, 5, primary opcode width
- INSTSIZE, 32'd4, instruction size in bytes

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  execute stage presents an instruction
- IN_READY  out  1  stage can accept; transfer occurs when IN_VALID&IN_READY at a rising edge
- OPCODE  in  OPCODEBITS  primary opcode
- ALUR  in  1  1 = register-register ALU instruction
- ALUOUT  in  DBITS  ALU result
- Z  in  1  branch condition (ALU result bit 0)
- PCPLUS4  in  DBITS  instruction PC + INSTSIZE
- BRTARGET  in  DBITS  precomputed branch target
- STDATA  in  DBITS  store data for SW
- DSTREG  in  REGNOBITS  destination register
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  DBITS  byte address
- MEM_WDATA  out  DBITS  store data
- MEM_ACK  in  1  memory completes the request this cycle
- MEM_RDATA  in  DBITS  load data, valid with MEM_ACK
- WB_EN  out  1  writeback pulse
- WB_REG  out  REGNOBITS  writeback register
- WB_DATA  out  DBITS  writeback data
- PC_REDIRECT  out  1  fetch redirect pulse
- PC_TARGET  out  DBITS  redirect target
- ILLEGAL  out  1  sticky error flag

Behaviour:
- Reset (async, RESET_N=0):
  - State IDLE.
  - All outputs 0: IN_READY, MEM_*, WB_*, PC_*, ILLEGAL.
  - Drops MEM_REQ immediately, even mid-access; the pending load/store is abandoned with no writeback.
  - IN_READY goes to 1 on the first edge after reset release.
- FSM states: IDLE and MEM_WAIT.
  - IN_READY = 1 only in IDLE.
  - IN_VALID is ignored in MEM_WAIT.
- Accept at edge k. Outputs below are registered and valid in cycle k+1.
  - WB_EN and PC_REDIRECT are single-cycle pulses; all other outputs hold their last value.
- Decode by instruction type:
  - ALUR=1: WB_EN=1, WB_REG=DSTREG, WB_DATA=ALUOUT; OPCODE is ignored.
  - ALUR=0 with ADDI 11000, ANDI 11100, ORI 11101 or XORI 11110: same as ALUR=1.
  - ALUR=0 with BEQ 10000, BLT 10001, BLE 10010 or BNE 10011:
    - No writeback.
    - If Z=1: PC_REDIRECT=1, PC_TARGET=BRTARGET.
    - If Z=0: nothing is issued.
  - JAL 10111: WB_EN=1, WB_DATA=PCPLUS4, WB_REG=DSTREG, PC_REDIRECT=1, PC_TARGET={ALUOUT[DBITS-1:2],2'b00}.
  - LW 01010:
    - MEM_REQ=1, MEM_WE=0, MEM_ADDR=ALUOUT; state goes to MEM_WAIT.
    - The request and all MEM_* signals are held stable until MEM_ACK=1 is sampled at edge m. MEM_ACK in cycle k+1 is legal, giving the minimum m=k+1.
    - At edge m: MEM_REQ drops to 0, MEM_RDATA is captured, state returns to IDLE.
    - In cycle m+1: WB_EN=1, WB_DATA=captured data, WB_REG=DSTREG of the load, IN_READY=1.
  - SW 01110:
    - Same handshake as LW with MEM_WE=1, MEM_WDATA=STDATA.
    - No writeback.
  - LW/SW with ALUOUT[1:0] != 0 (misaligned): no request, ILLEGAL set, treated as a NOP.
  - Any other ALUR=0 opcode: ILLEGAL set, treated as a NOP.
- MEM_ACK sampled while MEM_REQ=0 is ignored.
- ILLEGAL is cleared only by reset.
- Writes to register 0 are passed through unchanged; the register file discards them.
- A new instruction may be accepted in the same cycle a WB_EN/PC_REDIRECT pulse is output, giving back-to-back throughput of 1 per cycle for non-memory instructions.
- Arithmetic is not performed here except the JAL target alignment; all widths are DBITS with no extension.

Test Plan:
- Reset mid-wait: accept LW at ALUOUT=0x100, hold MEM_ACK=0, pulse RESET_N low -> MEM_REQ=0 immediately; no WB_EN ever; after release IN_READY=1, ILLEGAL=0.
- ALUR=1, ALUOUT=0xDEADBEEF, DSTREG=5, then ADDI with ALUOUT=7, DSTREG=6 on the next cycle -> WB_EN pulses in two consecutive cycles: (5,0xDEADBEEF) then (6,7); IN_READY stays 1.
- BEQ with Z=1, BRTARGET=0x40 -> PC_REDIRECT one cycle, PC_TARGET=0x40, WB_EN=0. BNE with Z=0 -> no redirect.
- JAL with ALUOUT=0x203, PCPLUS4=0x14, DSTREG=15 -> WB_EN (15,0x14) and PC_REDIRECT with PC_TARGET=0x200 in the same cycle.
- LW at 0x80, MEM_ACK after 3 wait cycles with MEM_RDATA=0x1234 -> MEM_REQ high 3 cycles with address stable, IN_READY low, WB_EN (DSTREG,0x1234) the cycle after ACK. Repeat with ACK in the first cycle -> writeback at k+2.
- SW at 0x82 -> no MEM_REQ, ILLEGAL=1, which persists. SW at 0x84 with STDATA=0xA5 -> MEM_WE=1, MEM_WDATA=0xA5, no WB_EN.
